// File: rtl/stim_scheduler_if.sv
// Signal bundle between a stimulation controller (master) and stim_scheduler (slave).
interface stim_scheduler_if #(
  parameter int NCH = 4,
  parameter int TW  = 16
);
  // Handshake: req[i] is a level held by the master while channel i wants pulses.
  // The scheduler answers with a one-hot grant held for the whole pulse, then a
  // one-cycle done strobe in the following IDLE cycle. Dropping req mid-pulse
  // never cuts the pulse short; abort is the only way to shorten a pulse.
  logic [NCH-1:0]   req;
  logic             abort;
  logic [5*NCH-1:0] mag_cfg;
  logic [TW-1:0]    t_lead, t_cat, t_ipd, t_ano, t_dis, t_tail;
  logic [NCH-1:0]   grant;
  logic             EN_ST, CAT_ST, ANO_ST, DIS_ST;
  logic [4:0]       MAG_ST;
  logic             busy, done;
  logic [2:0]       state_dbg;

  modport master (
    output req, abort, mag_cfg, t_lead, t_cat, t_ipd, t_ano, t_dis, t_tail,
    input  grant, EN_ST, CAT_ST, ANO_ST, DIS_ST, MAG_ST, busy, done, state_dbg
  );

  modport slave (
    input  req, abort, mag_cfg, t_lead, t_cat, t_ipd, t_ano, t_dis, t_tail,
    output grant, EN_ST, CAT_ST, ANO_ST, DIS_ST, MAG_ST, busy, done, state_dbg
  );
endinterface

// File: rtl/stim_scheduler.sv
// Round-robin biphasic pulse scheduler sharing one current driver across NCH channels.
// Optional macro STIM_RAMP_EN adds per-channel magnitude ramping after completed pulses.
module stim_scheduler #(
  parameter int NCH = 4,
  parameter int TW  = 16
) (
  input logic             clk,
  input logic             rst,
  stim_scheduler_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_CAT  = 3'd2;
  localparam logic [2:0] S_IPD  = 3'd3;
  localparam logic [2:0] S_ANO  = 3'd4;
  localparam logic [2:0] S_DIS  = 3'd5;
  localparam logic [2:0] S_TAIL = 3'd6;

  logic [2:0]    state, nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [TW-1:0] dur_in [6];
  logic [TW-1:0] dur_q  [6];
  logic [5:0]    nz_in, nz_q;
  logic [CW-1:0] ptr, ch_q, sel_ch, ch_nxt;
  logic          sel_found, start, pulse_end;
  logic [4:0]    mag_q, mag_raw, mag_sel;

  assign dur_in[0] = bus.t_lead;
  assign dur_in[1] = bus.t_cat;
  assign dur_in[2] = bus.t_ipd;
  assign dur_in[3] = bus.t_ano;
  assign dur_in[4] = bus.t_dis;
  assign dur_in[5] = bus.t_tail;

  assign bus.state_dbg = state;

  // First phase at or after 'from' whose duration is non-zero; IDLE if none remain.
  function automatic logic [2:0] first_phase(input logic [5:0] nz, input logic [2:0] from);
    logic [2:0] r;
    r = S_IDLE;
    for (int p = 6; p >= 1; p--) begin
      if (nz[p-1] && (3'(p) >= from)) r = 3'(p);
    end
    return r;
  endfunction

  always_comb begin
    nz_in = '0;
    nz_q  = '0;
    for (int i = 0; i < 6; i++) begin
      nz_in[i] = |dur_in[i];
      nz_q[i]  = |dur_q[i];
    end
  end

  // Round-robin search starting at ptr, which points just past the last grant.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!sel_found && bus.req[idx]) begin
        sel_found = 1'b1;
        sel_ch    = CW'(idx);
      end
    end
  end

  assign mag_raw = bus.mag_cfg[5*sel_ch +: 5];

  always_comb begin
    nxt   = state;
    start = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.abort && sel_found) begin
          start = 1'b1;
          nxt   = first_phase(nz_in, S_LEAD);
        end
      end
      S_LEAD: begin
        if (bus.abort)          nxt = S_IDLE;
        else if (timer == '0)   nxt = first_phase(nz_q, S_CAT);
      end
      S_CAT, S_IPD, S_ANO: begin
        if (bus.abort)          nxt = first_phase(nz_q, S_DIS);
        else if (timer == '0)   nxt = first_phase(nz_q, state + 3'd1);
      end
      S_DIS, S_TAIL: begin
        if (timer == '0)        nxt = first_phase(nz_q, state + 3'd1);
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    timer_nxt = '0;
    if (nxt != S_IDLE) begin
      if (nxt != state)
        timer_nxt = (start ? dur_in[nxt - 3'd1] : dur_q[nxt - 3'd1]) - TW'(1);
      else
        timer_nxt = timer - TW'(1);
    end
  end

  assign ch_nxt    = start ? sel_ch : ch_q;
  assign pulse_end = (nxt == S_IDLE) && (start || (state != S_IDLE));

`ifdef STIM_RAMP_EN
  logic [4:0] ramp [NCH];
  logic       aborted_q, abort_hit, complete_ok;

  assign mag_sel     = (ramp[sel_ch] < mag_raw) ? ramp[sel_ch] : mag_raw;
  assign abort_hit   = bus.abort && (state >= S_LEAD) && (state <= S_ANO);
  assign complete_ok = start ? (nxt == S_IDLE)
                             : ((state != S_IDLE) && (nxt == S_IDLE) && !aborted_q && !abort_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted_q <= 1'b0;
      for (int i = 0; i < NCH; i++) ramp[i] <= '0;
    end else begin
      if (start)          aborted_q <= 1'b0;
      else if (abort_hit) aborted_q <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (!bus.req[i])
          ramp[i] <= '0;
        else if (complete_ok && (ch_nxt == CW'(i)))
          ramp[i] <= (ramp[i] >= bus.mag_cfg[5*i +: 5]) ? bus.mag_cfg[5*i +: 5] : ramp[i] + 5'd1;
      end
    end
  end
`else
  assign mag_sel = mag_raw;
`endif

  // Outputs are registered from nxt so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      ptr        <= '0;
      ch_q       <= '0;
      mag_q      <= '0;
      for (int i = 0; i < 6; i++) dur_q[i] <= '0;
      bus.grant  <= '0;
      bus.EN_ST  <= 1'b0;
      bus.CAT_ST <= 1'b0;
      bus.ANO_ST <= 1'b0;
      bus.DIS_ST <= 1'b0;
      bus.MAG_ST <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state <= nxt;
      timer <= timer_nxt;
      if (start) begin
        ch_q  <= sel_ch;
        mag_q <= mag_sel;
        ptr   <= (sel_ch == CW'(NCH-1)) ? '0 : sel_ch + CW'(1);
        for (int i = 0; i < 6; i++) dur_q[i] <= dur_in[i];
      end
      bus.grant  <= (nxt != S_IDLE) ? (NCH'(1) << ch_nxt) : '0;
      bus.EN_ST  <= (nxt != S_IDLE);
      bus.CAT_ST <= (nxt == S_CAT);
      bus.ANO_ST <= (nxt == S_ANO);
      bus.DIS_ST <= (nxt == S_DIS);
      bus.MAG_ST <= (nxt != S_IDLE) ? (start ? mag_sel : mag_q) : 5'd0;
      bus.busy   <= (nxt != S_IDLE);
      bus.done   <= pulse_end;
    end
  end
endmodule

// File: tb/tb_stim_scheduler.sv
// Bench for stim_scheduler: transaction-level pulse model expands each granted pulse
// into a queue of expected output words; compile with STIM_RAMP_EN to cover ramping.
module tb_stim_scheduler;
  localparam int NCH = 4;
  localparam int TW  = 16;
  localparam int W   = NCH + 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stim_scheduler_if #(.NCH(NCH), .TW(TW)) bus ();
  stim_scheduler #(.NCH(NCH), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected output word per cycle: {grant, EN, CAT, ANO, DIS, MAG, busy, done}
  logic [W-1:0] exp_q[$];
  int           ph_q[$];
  bit           ok_q[$];

  int         ptr, cur_ph, lat_ch, lat_dis, lat_tail;
  logic [4:0] lat_mag;
  int         ramp[NCH];

  int en_cnt, cat_cnt, ano_cnt, dis_cnt, done_cnt, fall_rise, en_cat_rise;
  logic prev_en, prev_cat, prev_busy;
  logic [NCH-1:0] prev_grant;
  logic [NCH-1:0] gseq[$];
  int mseq[$];

  logic [NCH-1:0] g_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef STIM_RAMP_EN
  int m_exp[5] = '{0, 1, 2, 3, 3};
  int m_re     = 0;
`else
  int m_exp[5] = '{3, 3, 3, 3, 3};
  int m_re     = 3;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cfg_of(input int ch);
    return int'(bus.mag_cfg[5*ch +: 5]);
  endfunction

  task automatic push_phase(input int ph, input int d);
    logic [3:0] ctl;
    case (ph)
      2:       ctl = 4'b1100;
      4:       ctl = 4'b1010;
      5:       ctl = 4'b1001;
      default: ctl = 4'b1000;
    endcase
    for (int n = 0; n < d; n++) begin
      exp_q.push_back({NCH'(1 << lat_ch), ctl, lat_mag, 1'b1, 1'b0});
      ph_q.push_back(ph);
      ok_q.push_back(1'b0);
    end
  endtask

  task automatic push_done(input bit ok);
    exp_q.push_back(W'(1));
    ph_q.push_back(0);
    ok_q.push_back(ok);
  endtask

  task automatic model_select();
    int ch;
    int d[6];
    ch = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (ptr + k) % NCH;
      if (ch < 0 && bus.req[c]) ch = c;
    end
    lat_ch  = ch;
    ptr     = (ch + 1) % NCH;
    lat_mag = 5'(cfg_of(ch));
`ifdef STIM_RAMP_EN
    if (ramp[ch] < cfg_of(ch)) lat_mag = 5'(ramp[ch]);
`endif
    d = '{int'(bus.t_lead), int'(bus.t_cat), int'(bus.t_ipd),
          int'(bus.t_ano), int'(bus.t_dis), int'(bus.t_tail)};
    lat_dis  = d[4];
    lat_tail = d[5];
    for (int p = 1; p <= 6; p++) push_phase(p, d[p-1]);
    push_done(1'b1);
  endtask

  // Decisions taken on the inputs sampled at the coming edge.
  task automatic model_pre();
    if (cur_ph == 0 && exp_q.size() == 0) begin
      if (!bus.abort && bus.req != '0) model_select();
    end else if (bus.abort && cur_ph >= 1 && cur_ph <= 4) begin
      exp_q.delete();
      ph_q.delete();
      ok_q.delete();
      if (cur_ph != 1) begin
        push_phase(5, lat_dis);
        push_phase(6, lat_tail);
      end
      push_done(1'b0);
    end
`ifdef STIM_RAMP_EN
    for (int i = 0; i < NCH; i++) begin
      if (!bus.req[i])
        ramp[i] = 0;
      else if (exp_q.size() > 0 && ph_q[0] == 0 && ok_q[0] && lat_ch == i)
        ramp[i] = (ramp[i] + 1 < cfg_of(i)) ? ramp[i] + 1 : cfg_of(i);
    end
`endif
  endtask

  task automatic model_post();
    logic [W-1:0] e, g;
    cyc++;
    if (exp_q.size() == 0) begin
      e = '0;
      cur_ph = 0;
    end else begin
      e = exp_q.pop_front();
      cur_ph = ph_q.pop_front();
      void'(ok_q.pop_front());
    end
    g = {bus.grant, bus.EN_ST, bus.CAT_ST, bus.ANO_ST, bus.DIS_ST, bus.MAG_ST, bus.busy, bus.done};
    check($sformatf("out@%0d", cyc), 32'(g), 32'(e));
    check("excl", 32'(int'(bus.CAT_ST) + int'(bus.ANO_ST) + int'(bus.DIS_ST) <= 1), 32'd1);
    en_cnt   += int'(bus.EN_ST);
    cat_cnt  += int'(bus.CAT_ST);
    ano_cnt  += int'(bus.ANO_ST);
    dis_cnt  += int'(bus.DIS_ST);
    done_cnt += int'(bus.done);
    if (prev_cat && !bus.CAT_ST && bus.ANO_ST) fall_rise++;
    if (!prev_en && bus.EN_ST && bus.CAT_ST) en_cat_rise++;
    if (bus.grant != '0 && prev_grant == '0) gseq.push_back(bus.grant);
    if (bus.busy && !prev_busy) mseq.push_back(int'(bus.MAG_ST));
    prev_en    = bus.EN_ST;
    prev_cat   = bus.CAT_ST;
    prev_busy  = bus.busy;
    prev_grant = bus.grant;
  endtask

  task automatic tick();
    model_pre();
    @(posedge clk);
    #1;
    model_post();
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    ph_q.delete();
    ok_q.delete();
    ptr = 0;
    cur_ph = 0;
    lat_ch = 0;
    for (int i = 0; i < NCH; i++) ramp[i] = 0;
    prev_en = 1'b0;
    prev_cat = 1'b0;
    prev_busy = 1'b0;
    prev_grant = '0;
  endtask

  task automatic clear_counts();
    en_cnt = 0; cat_cnt = 0; ano_cnt = 0; dis_cnt = 0; done_cnt = 0;
    fall_rise = 0; en_cat_rise = 0;
  endtask

  task automatic set_durs(input int a, input int b, input int c, input int d, input int e, input int f);
    bus.t_lead = TW'(a);
    bus.t_cat  = TW'(b);
    bus.t_ipd  = TW'(c);
    bus.t_ano  = TW'(d);
    bus.t_dis  = TW'(e);
    bus.t_tail = TW'(f);
  endtask

  function automatic int rnd_dur();
    if ($urandom_range(0, 2) == 0) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  task automatic drain();
    bus.req = '0;
    bus.abort = 1'b0;
    repeat (24) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.abort = 1'b0;
    bus.mag_cfg = '0;
    set_durs(0, 0, 0, 0, 0, 0);
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) tick();

    // all channels requesting: strict round-robin with idle gaps
    bus.mag_cfg = {5'd4, 5'd3, 5'd2, 5'd1};
    set_durs(1, 1, 1, 1, 1, 1);
    gseq.delete();
    bus.req = 4'b1111;
    for (int n = 0; n < 200 && gseq.size() < 5; n++) tick();
    bus.req = '0;
    if (gseq.size() < 5) check("rr_timeout", 32'(gseq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gseq.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(gseq[i]), 32'(g_exp[i]));
    drain();

    // single pulse, req dropped after selection
    set_durs(2, 5, 1, 5, 1, 2);
    clear_counts();
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    repeat (20) tick();
    check("p1_en", 32'(en_cnt), 32'd16);
    check("p1_cat", 32'(cat_cnt), 32'd5);
    check("p1_ano", 32'(ano_cnt), 32'd5);
    check("p1_dis", 32'(dis_cnt), 32'd1);
    check("p1_done", 32'(done_cnt), 32'd1);

    // abort in the third CAT cycle
    set_durs(1, 6, 1, 3, 4, 2);
    begin
      int cat_seen;
      cat_seen = 0;
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      for (int n = 0; n < 40 && cat_seen < 3; n++) begin
        tick();
        if (bus.CAT_ST) cat_seen++;
      end
      if (cat_seen < 3) check("ab_timeout", 32'(cat_seen), 32'd3);
    end
    clear_counts();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (12) tick();
    check("ab_cat", 32'(cat_cnt), 32'd0);
    check("ab_dis", 32'(dis_cnt), 32'd4);
    check("ab_done", 32'(done_cnt), 32'd1);

    // zero lead and zero inter-phase gap
    set_durs(0, 3, 0, 2, 1, 1);
    clear_counts();
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    repeat (10) tick();
    check("z_fall_rise", 32'(fall_rise), 32'd1);
    check("z_en_cat", 32'(en_cat_rise), 32'd1);

    // all-zero pulse still strobes done
    set_durs(0, 0, 0, 0, 0, 0);
    clear_counts();
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    repeat (3) tick();
    check("zero_done", 32'(done_cnt), 32'd1);
    check("zero_en", 32'(en_cnt), 32'd0);
    drain();

    // magnitude per pulse with req held, then after a req drop
    set_durs(1, 1, 1, 1, 1, 1);
    bus.mag_cfg = 20'd3;
    mseq.delete();
    bus.req = 4'b0001;
    for (int n = 0; n < 100 && mseq.size() < 5; n++) tick();
    bus.req = '0;
    if (mseq.size() < 5) check("mag_timeout", 32'(mseq.size()), 32'd5);
    for (int i = 0; i < 5 && i < mseq.size(); i++)
      check($sformatf("mag%0d", i), 32'(mseq[i]), 32'(m_exp[i]));
    repeat (10) tick();
    mseq.delete();
    bus.req = 4'b0001;
    for (int n = 0; n < 20 && mseq.size() < 1; n++) tick();
    bus.req = '0;
    if (mseq.size() < 1) check("mag_re_timeout", 32'(mseq.size()), 32'd1);
    else check("mag_re", 32'(mseq[0]), 32'(m_re));
    drain();

    // randomized traffic against the model
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 9) == 0)
        set_durs(rnd_dur(), rnd_dur(), rnd_dur(), rnd_dur(), rnd_dur(), rnd_dur());
      if ($urandom_range(0, 3) == 0) bus.req = NCH'($urandom_range(0, 15));
      bus.abort = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 19) == 0) bus.mag_cfg = 20'($urandom());
      tick();
    end
    drain();

    // reset asserted in the middle of ANO
    set_durs(1, 1, 1, 6, 1, 1);
    bus.mag_cfg = {5'd6, 5'd5, 5'd4, 5'd7};
    bus.req = 4'b0001;
    begin
      int hit;
      hit = 0;
      for (int n = 0; n < 30 && hit == 0; n++) begin
        tick();
        if (bus.ANO_ST) hit = 1;
      end
      if (hit == 0) check("rst_ano_timeout", 32'(hit), 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_ctl", 32'({bus.EN_ST, bus.CAT_ST, bus.ANO_ST, bus.DIS_ST}), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'({bus.busy, bus.done}), 32'd0);
    check("rst_mag", 32'(bus.MAG_ST), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.req = 4'b0010;
    begin
      int got_grant;
      got_grant = 0;
      for (int n = 0; n < 10 && got_grant == 0; n++) begin
        tick();
        if (bus.grant != '0) begin
          got_grant = 1;
          check("rst_regrant", 32'(bus.grant), 32'b0010);
        end
      end
      if (got_grant == 0) check("rst_regrant_timeout", 32'(got_grant), 32'd1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
